// File: rtl/fft_spectrum_scanner.sv
// One-pass scan of the FFT power RAM: peak bin/power, low/mid/high band sums
// and a loudness flag, started by each rising edge of the FFT completion level.
module fft_spectrum_scanner #(
  parameter int BITS    = 16,
  parameter int ABITS   = 9,
  parameter int NBINS   = 512,
  parameter int RD_LAT  = 2,
  parameter int MIN_BIN = 1,
  parameter int LOW_END = 32,
  parameter int MID_END = 128,
  parameter int THRESH  = 200
) (
  input  logic                  iStateClk,
  input  logic                  iReset,
  input  logic                  iDone,
  output logic [ABITS-1:0]      oReadAddr,
  input  logic [BITS-1:0]       iPower,
  output logic [ABITS-1:0]      oPeakBin,
  output logic [BITS-1:0]       oPeakPow,
  output logic [BITS+ABITS-1:0] oLowSum,
  output logic [BITS+ABITS-1:0] oMidSum,
  output logic [BITS+ABITS-1:0] oHighSum,
  output logic                  oLoud,
  output logic                  oValid,
  output logic                  oBusy,
  output logic                  oMissed
);
  // state | meaning
  // IDLE  | waiting for an iDone rising edge, read address parked at 0
  // SCAN  | presenting read addresses 0..NBINS-1
  // DRAIN | RD_LAT cycles for in-flight reads to return
  // DONE  | new results presented, oValid high
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

  localparam int SW = BITS + ABITS;
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t            state_q, state_d;
  logic              done_q;
  logic [ABITS-1:0]  addr_q, addr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              vld_q [RD_LAT];
  logic [ABITS-1:0]  bin_q [RD_LAT];
  logic [BITS-1:0]   peak_q, peak_d;
  logic [ABITS-1:0]  pbin_q, pbin_d;
  logic [SW-1:0]     low_q, low_d, mid_q, mid_d, high_q, high_d;
  logic [ABITS-1:0]  out_bin_q;
  logic [BITS-1:0]   out_pow_q;
  logic [SW-1:0]     out_low_q, out_mid_q, out_high_q;
  logic              out_loud_q, missed_q;
  logic              start, clr_acc, load_out, smp_vld;
  logic [ABITS-1:0]  smp_bin;
  logic [BITS-1:0]   p_clamp;

  assign start   = iDone & ~done_q;
  assign smp_bin = bin_q[RD_LAT-1];
  assign smp_vld = vld_q[RD_LAT-1] && (smp_bin >= ABITS'(MIN_BIN));
  assign p_clamp = iPower[BITS-1] ? '0 : iPower;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    clr_acc  = 1'b0;
    load_out = 1'b0;
    case (state_q)
      S_IDLE: begin
        addr_d = '0;
        if (start) begin
          state_d = S_SCAN;
          clr_acc = 1'b1;
        end
      end
      S_SCAN: begin
        if (addr_q == ABITS'(NBINS-1)) begin
          state_d = S_DRAIN;
          addr_d  = '0;
          cnt_d   = CW'(RD_LAT-1);
        end else begin
          addr_d = addr_q + ABITS'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          load_out = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Ties keep the earlier bin because only a strictly larger power replaces the peak.
  always_comb begin
    peak_d = peak_q;
    pbin_d = pbin_q;
    low_d  = low_q;
    mid_d  = mid_q;
    high_d = high_q;
    if (clr_acc) begin
      peak_d = '0;
      pbin_d = '0;
      low_d  = '0;
      mid_d  = '0;
      high_d = '0;
    end else if (smp_vld) begin
      if (p_clamp > peak_q) begin
        peak_d = p_clamp;
        pbin_d = smp_bin;
      end
      if (smp_bin < ABITS'(LOW_END))      low_d  = low_q + SW'(p_clamp);
      else if (smp_bin < ABITS'(MID_END)) mid_d  = mid_q + SW'(p_clamp);
      else                                high_d = high_q + SW'(p_clamp);
    end
  end

  always_ff @(posedge iStateClk) begin
    if (iReset) begin
      state_q    <= S_IDLE;
      done_q     <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        vld_q[i] <= 1'b0;
        bin_q[i] <= '0;
      end
      peak_q     <= '0;
      pbin_q     <= '0;
      low_q      <= '0;
      mid_q      <= '0;
      high_q     <= '0;
      out_bin_q  <= '0;
      out_pow_q  <= '0;
      out_low_q  <= '0;
      out_mid_q  <= '0;
      out_high_q <= '0;
      out_loud_q <= 1'b0;
      missed_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      done_q   <= iDone;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      // Stage 0 tags the address being presented this cycle.
      vld_q[0] <= (state_d == S_SCAN);
      bin_q[0] <= addr_d;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        bin_q[i] <= bin_q[i-1];
      end
      peak_q   <= peak_d;
      pbin_q   <= pbin_d;
      low_q    <= low_d;
      mid_q    <= mid_d;
      high_q   <= high_d;
      missed_q <= start && (state_q != S_IDLE);
      if (load_out) begin
        out_bin_q  <= pbin_q;
        out_pow_q  <= peak_q;
        out_low_q  <= low_q;
        out_mid_q  <= mid_q;
        out_high_q <= high_q;
        out_loud_q <= (peak_q > BITS'(THRESH));
      end
    end
  end

  assign oReadAddr = addr_q;
  assign oPeakBin  = out_bin_q;
  assign oPeakPow  = out_pow_q;
  assign oLowSum   = out_low_q;
  assign oMidSum   = out_mid_q;
  assign oHighSum  = out_high_q;
  assign oLoud     = out_loud_q;
  assign oValid    = (state_q == S_DONE);
  assign oBusy     = (state_q == S_SCAN) || (state_q == S_DRAIN);
  assign oMissed   = missed_q;

endmodule

// File: tb/tb_fft_spectrum_scanner.sv
// Bench for fft_spectrum_scanner: RAM model with exact read latency, table of
// spectra with expected results, scoreboard queue, and busy/reset corner cases.
module tb_fft_spectrum_scanner;
  localparam int RD_LAT = 2;

  typedef struct {
    int pbin;
    int ppow;
    int low;
    int mid;
    int high;
    int loud;
  } exp_t;

  typedef struct {
    int   pat;
    exp_t e;
  } vec_t;

  logic        clk;
  logic        iReset;
  logic        iDone;
  logic [8:0]  oReadAddr;
  logic [15:0] iPower;
  logic [8:0]  oPeakBin;
  logic [15:0] oPeakPow;
  logic [24:0] oLowSum, oMidSum, oHighSum;
  logic        oLoud, oValid, oBusy, oMissed;

  fft_spectrum_scanner dut (
    .iStateClk (clk),
    .iReset    (iReset),
    .iDone     (iDone),
    .oReadAddr (oReadAddr),
    .iPower    (iPower),
    .oPeakBin  (oPeakBin),
    .oPeakPow  (oPeakPow),
    .oLowSum   (oLowSum),
    .oMidSum   (oMidSum),
    .oHighSum  (oHighSum),
    .oLoud     (oLoud),
    .oValid    (oValid),
    .oBusy     (oBusy),
    .oMissed   (oMissed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM read side: data for the address presented in one cycle appears RD_LAT-1 cycles later.
  logic [15:0] mem [512];
  logic [8:0]  rd_pipe [RD_LAT-1];
  always @(posedge clk) begin
    rd_pipe[0] <= oReadAddr;
    for (int i = 1; i < RD_LAT-1; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign iPower = mem[rd_pipe[RD_LAT-2]];

  int   cyc = 0;
  int   vcount = 0;
  int   mcount = 0;
  int   e0 = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_runs = 0;
  exp_t exp_q[$];
  vec_t vecs[7];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    vcount <= vcount + int'(oValid);
    mcount <= mcount + int'(oMissed);
  end

  task automatic check(input string nm, input longint act, input longint expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic fill(input int pat);
    for (int k = 0; k < 512; k++) begin
      case (pat)
        0: mem[k] = 16'd10;
        2: mem[k] = 16'h8000;
        3: mem[k] = 16'd32767;
        7: mem[k] = 16'($urandom);
        default: mem[k] = 16'd0;
      endcase
    end
    case (pat)
      0: mem[100] = 16'd5000;
      1: begin mem[40] = 16'd7000; mem[300] = 16'd7000; end
      2: mem[0] = 16'd30000;
      4: mem[5] = 16'd200;
      5: mem[500] = 16'd201;
      6: begin
        mem[31] = 16'd1; mem[32] = 16'd2; mem[127] = 16'd4;
        mem[128] = 16'd8; mem[511] = 16'd16;
      end
      default: ;
    endcase
  endtask

  function automatic exp_t model();
    exp_t r;
    int   p;
    r = '{0, 0, 0, 0, 0, 0};
    for (int k = 1; k < 512; k++) begin
      p = mem[k][15] ? 0 : int'(mem[k]);
      if (p > r.ppow) begin
        r.ppow = p;
        r.pbin = k;
      end
      if (k < 32) r.low += p;
      else if (k < 128) r.mid += p;
      else r.high += p;
    end
    r.loud = (r.ppow > 200) ? 1 : 0;
    return r;
  endfunction

  // Raises iDone; the next posedge is E0. iDone stays high until released by the caller.
  task automatic start_scan(input exp_t e, input bit push);
    @(negedge clk);
    iDone = 1'b1;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    e0 = cyc;
  endtask

  task automatic wait_result(input string tag);
    exp_t e;
    bit   got;
    got = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(posedge clk);
      #1;
      if (oValid) got = 1;
    end
    if (!got) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s.timeout: oValid not seen within 3000 cycles, required one", tag);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    n_runs++;
    check({tag, ".latency"}, cyc - e0, 514);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s.scoreboard: result with no expected entry, required one queued", tag);
      return;
    end
    e = exp_q.pop_front();
    check({tag, ".peak_bin"}, oPeakBin, e.pbin);
    check({tag, ".peak_pow"}, oPeakPow, e.ppow);
    check({tag, ".low_sum"},  oLowSum,  e.low);
    check({tag, ".mid_sum"},  oMidSum,  e.mid);
    check({tag, ".high_sum"}, oHighSum, e.high);
    check({tag, ".loud"},     oLoud,    e.loud);
    check({tag, ".busy_in_done"}, oBusy, 0);
    @(posedge clk);
    #1;
    check({tag, ".valid_pulse"}, oValid, 0);
  endtask

  initial begin
    int   v0, m0;
    exp_t er;

    vecs[0] = '{0, '{100, 5000, 310, 5950, 3840, 1}};
    vecs[1] = '{1, '{40, 7000, 0, 7000, 7000, 1}};
    vecs[2] = '{2, '{0, 0, 0, 0, 0, 0}};
    vecs[3] = '{3, '{1, 32767, 1015777, 3145632, 12582528, 1}};
    vecs[4] = '{4, '{5, 200, 200, 0, 0, 0}};
    vecs[5] = '{5, '{500, 201, 0, 0, 201, 1}};
    vecs[6] = '{6, '{511, 16, 1, 6, 24, 0}};

    iReset = 1'b1;
    iDone  = 1'b0;
    fill(0);
    repeat (4) @(posedge clk);
    #1;
    check("rst.valid", oValid, 0);
    check("rst.busy", oBusy, 0);
    check("rst.missed", oMissed, 0);
    check("rst.addr", oReadAddr, 0);
    check("rst.peak_bin", oPeakBin, 0);
    check("rst.peak_pow", oPeakPow, 0);
    check("rst.sums", oLowSum | oMidSum | oHighSum, 0);
    check("rst.loud", oLoud, 0);
    @(negedge clk);
    iReset = 1'b0;
    repeat (3) @(posedge clk);

    for (int i = 0; i < 7; i++) begin
      fill(vecs[i].pat);
      start_scan(vecs[i].e, 1);
      check($sformatf("vec%0d.busy_at_start", i), oBusy, 1);
      wait_result($sformatf("vec%0d", i));
      @(negedge clk);
      iDone = 1'b0;
      repeat (3) @(posedge clk);
    end

    fill(7);
    er = model();
    start_scan(er, 1);
    wait_result("random");
    @(negedge clk);
    iDone = 1'b0;
    repeat (3) @(posedge clk);

    // Second rising edge mid-scan: ignored, flagged once, results undisturbed.
    fill(0);
    #1;
    v0 = vcount;
    m0 = mcount;
    start_scan(vecs[0].e, 1);
    repeat (200) @(posedge clk);
    @(negedge clk);
    iDone = 1'b0;
    @(negedge clk);
    iDone = 1'b1;
    wait_result("busy_start");
    repeat (600) @(posedge clk);
    #1;
    check("busy_start.missed_pulses", mcount - m0, 1);
    check("busy_start.valid_pulses", vcount - v0, 1);
    @(negedge clk);
    iDone = 1'b0;
    repeat (3) @(posedge clk);

    // Reset mid-scan with iDone held high: outputs clear, then a start right after release.
    fill(6);
    start_scan(vecs[6].e, 0);
    repeat (200) @(posedge clk);
    @(negedge clk);
    iReset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst.busy", oBusy, 0);
    check("midrst.valid", oValid, 0);
    check("midrst.addr", oReadAddr, 0);
    check("midrst.peak_bin", oPeakBin, 0);
    check("midrst.peak_pow", oPeakPow, 0);
    check("midrst.sums", oLowSum | oMidSum | oHighSum, 0);
    check("midrst.loud", oLoud, 0);
    repeat (2) @(posedge clk);
    fill(0);
    @(negedge clk);
    iReset = 1'b0;
    exp_q.push_back(vecs[0].e);
    @(posedge clk);
    #1;
    e0 = cyc;
    wait_result("after_reset");
    @(negedge clk);
    iDone = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    check("total.valid_pulses", vcount, n_runs);
    check("total.missed_pulses", mcount, 1);
    check("scoreboard.empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_spectrum_scanner.md
# fft_spectrum_scanner

Reads the 512-bin power spectrum that the FFT controller writes into its `ram512x16` buffer, starting each time that controller signals completion. In one pass it produces the peak bin index, the peak power, three band-energy sums (low/mid/high) and a loudness flag. The game logic consumes these as audio control inputs. The block drives the read side of the power RAM, with `iReadClock` tied to `iStateClk`.

## Interface
- `BITS`, 16: power word width. Power words are signed.
- `ABITS`, 9: bin address width.
- `NBINS`, 512: bins scanned per pass.
- `RD_LAT`, 2: cycles from address presented to `iPower` valid.
- `MIN_BIN`, 1: bins below this are excluded from the peak search and from all sums (DC rejection).
- `LOW_END`, 32: first bin of the mid band.
- `MID_END`, 128: first bin of the high band.
- `THRESH`, 200: `oLoud` threshold on peak power.

Ports:
- `iStateClk`, in, 1: clock.
- `iReset`, in, 1: synchronous, active-high reset.
- `iDone`, in, 1: completion level from the FFT controller. A rising edge starts a scan.
- `oReadAddr`, out, `ABITS`: RAM read address.
- `iPower`, in, `BITS`: RAM read data.
- `oPeakBin`, out, `ABITS`: bin of maximum power.
- `oPeakPow`, out, `BITS`: maximum power, unsigned, with negative inputs clamped to 0.
- `oLowSum`, `oMidSum`, `oHighSum`, out, `BITS+ABITS` each: unsigned band sums.
- `oLoud`, out, 1: `oPeakPow > THRESH`.
- `oValid`, out, 1: one-cycle pulse when a new result is presented.
- `oBusy`, out, 1: high during SCAN and DRAIN.
- `oMissed`, out, 1: one-cycle pulse when an `iDone` rising edge is ignored.

## Operation
- **Edge detect.** `iDone` is registered into `done_q`. A start is `iDone & ~done_q`.
- **States:** IDLE, SCAN, DRAIN, DONE.
- **IDLE:**
  - `oReadAddr` = 0.
  - On start: go to SCAN and clear the working accumulators (peak = 0, bin = 0, sums = 0).
- **SCAN:**
  - `oReadAddr` increments by 1 per cycle from 0 to `NBINS-1`.
  - A shift pipeline `RD_LAT` deep carries a valid bit and the bin index alongside each address.
  - After address `NBINS-1` is presented, go to DRAIN.
- **DRAIN:** lasts `RD_LAT` cycles so the last samples are processed, then go to DONE.
- **Per returned sample (bin k, value p):**
  - `p` is clamped: if `p[BITS-1]` = 1, use 0.
  - If k < `MIN_BIN`, discard the sample.
  - Peak update only on strictly greater (`p > peak`). Ties keep the lowest bin.
  - Band select:
    - k < `LOW_END` adds to low.
    - `LOW_END` ≤ k < `MID_END` adds to mid.
    - Otherwise adds to high.
  - Sums are `BITS+ABITS` bits wide and never overflow (512 × 32767 < 2^25).
- **DONE:**
  - Copy the accumulators to the output registers.
  - Compute `oLoud` from the new peak value.
  - Pulse `oValid` for one cycle, then return to IDLE.
- **Output hold.** Outputs hold their values until the next DONE.
- **Start while busy.** A start detected in SCAN, DRAIN or DONE is ignored and produces a one-cycle `oMissed` pulse. It is not queued.
- **`iDone` held high.** This produces only one start.
- **Reset, including mid-scan.** State goes to IDLE and the pipeline is cleared. All outputs go to 0, `done_q` goes to 0, and no `oValid` is produced.
- **`iDone` high at reset release.** A start occurs on the first cycle after reset, because `done_q` is 0.

## Timing
- Reset value of every output: 0.
- Start sampled at edge E0: from E0 onward, state = SCAN, `oReadAddr` = 0 and `oBusy` = 1.
- Address k is presented during the cycle after edge E0+k. Its data is sampled at edge E0+k+1+`RD_LAT`−1 = E0+k+`RD_LAT`.
- The last sample is accumulated at edge E0+`NBINS`−1+`RD_LAT`.
- Result registers load, and `oValid` goes high, at edge E0+`NBINS`+`RD_LAT`. `oValid` is high for exactly one cycle.
- With the defaults, `oValid` occurs 514 cycles after E0.
- `oBusy` is high for `NBINS`+`RD_LAT` cycles and low during the DONE cycle.
- Minimum start-to-start spacing is `NBINS`+`RD_LAT`+2 cycles. The FFT frame period far exceeds this.
- The RAM model in the bench must honour `RD_LAT` exactly. An off-by-one shifts every bin by one.

## Test plan
- **Single tone.** Bin 100 = 5000, all other bins = 10 → `oPeakBin`=100, `oPeakPow`=5000, `oLowSum`=310, `oMidSum`=5950, `oHighSum`=3840, `oLoud`=1, `oValid` 514 cycles after start.
- **Tie.** Bins 40 and 300 = 7000, others 0 → `oPeakBin`=40, `oPeakPow`=7000, `oMidSum`=7000, `oHighSum`=7000, `oLowSum`=0.
- **DC and negatives.** Bin 0 = 30000, bins 1–511 = 16'h8000 → `oPeakBin`=0, `oPeakPow`=0, all sums 0, `oLoud`=0.
- **Full scale.** All bins = 32767 → `oLowSum`=1015777, `oMidSum`=3145632, `oHighSum`=12582528, `oPeakBin`=1.
- **Busy start.** Second `iDone` rising edge at bin 200 → one `oMissed` pulse, a single `oValid`, and results identical to an undisturbed run.
- **Mid-scan reset.** `iReset` asserted at bin 200 → next cycle all outputs 0, state IDLE, no `oValid`. A following start produces a correct full result.
